// File: rtl/ex_div.sv
// ----------------------------------------------------------------------------
// ex_div -- iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Sits beside the ALU in EX. While a divide occupies EX it raises
// stall_req_ex so the front of the pipeline holds. It drops the request for
// the single DONE cycle so the instruction leaves EX with its result.
//
// Ports:
//   clk           clock
//   rst           synchronous reset, active-high
//   start         ID/EX holds a divide (held high while it sits in EX)
//   op [1:0]      00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with start in IDLE)
//   rs1 [XLEN-1:0] dividend (sampled with start in IDLE)
//   rs2 [XLEN-1:0] divisor  (sampled with start in IDLE)
//   flush         cancel any operation in flight (priority over start)
//   stall_req_ex  stall request to the stall controller (combinational)
//   done          one-cycle pulse, result valid
//   result        quotient or remainder; holds until the next done
//
// Build option:
//   DIV_EARLY_OUT_EN  when defined, divide-by-zero and signed overflow skip
//                     the iteration and go IDLE -> DONE directly. The result
//                     values are identical either way.
// ----------------------------------------------------------------------------
module ex_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall_req_ex,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [1:0]      op_reg;
    logic [XLEN-1:0] dvd_reg;      // dividend shifts out MSB-first, quotient shifts in
    logic [XLEN-1:0] dsr_reg;      // divisor magnitude
    logic [XLEN-1:0] rem_reg;      // partial remainder (always < divisor)
    logic [XLEN-1:0] rs1_reg;      // original rs1, needed for the divide-by-zero remainder
    logic            neg_quo_reg;
    logic            neg_rem_reg;
    logic            div0_reg;
    logic            ovf_reg;
    logic [XLEN-1:0] result_reg;

    // Result forced by the RISC-V special cases: divide by zero gives
    // quotient all ones / remainder rs1; signed overflow gives MIN / 0.
    function automatic logic [XLEN-1:0] special_res(
        input logic [1:0]      o,
        input logic            d0,
        input logic [XLEN-1:0] a
    );
        if (d0)
            return o[1] ? a : '1;
        else
            return o[1] ? '0 : MIN_NEG;
    endfunction

    // ---------------- operand preparation (IDLE) ----------------
    logic            is_signed;
    logic            rs1_neg, rs2_neg;
    logic [XLEN-1:0] rs1_mag, rs2_mag;
    logic            div0_in, ovf_in, special_in;
    logic            accept;

    assign is_signed  = ~op[0];
    assign rs1_neg    = is_signed & rs1[XLEN-1];
    assign rs2_neg    = is_signed & rs2[XLEN-1];
    assign rs1_mag    = rs1_neg ? -rs1 : rs1;
    assign rs2_mag    = rs2_neg ? -rs2 : rs2;
    assign div0_in    = (rs2 == '0);
    assign ovf_in     = is_signed & (rs1 == MIN_NEG) & (rs2 == '1);
    assign special_in = div0_in | ovf_in;
    assign accept     = (state_reg == IDLE) & start & ~flush;

    // ---------------- one restoring step (BUSY) ----------------
    // The trial remainder is XLEN+1 bits. Because rem_reg < divisor, the
    // difference can never reach 2^XLEN when positive, so its top bit is a
    // clean borrow flag.
    logic [XLEN:0]   trial, sub;
    logic            q_bit;
    logic [XLEN-1:0] rem_step, dvd_step;
    logic            last_step;
    logic [XLEN-1:0] quo_fix, rem_fix, final_res;

    assign trial     = {rem_reg, dvd_reg[XLEN-1]};
    assign sub       = trial - {1'b0, dsr_reg};
    assign q_bit     = ~sub[XLEN];
    assign rem_step  = q_bit ? sub[XLEN-1:0] : trial[XLEN-1:0];
    assign dvd_step  = {dvd_reg[XLEN-2:0], q_bit};
    assign last_step = (cnt_reg == CW'(XLEN-1));

    assign quo_fix   = neg_quo_reg ? -dvd_step : dvd_step;
    assign rem_fix   = neg_rem_reg ? -rem_step : rem_step;
    assign final_res = (div0_reg | ovf_reg) ? special_res(op_reg, div0_reg, rs1_reg)
                                            : (op_reg[1] ? rem_fix : quo_fix);

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
`ifdef DIV_EARLY_OUT_EN
                    state_next = special_in ? DONE : BUSY;
`else
                    state_next = BUSY;
`endif
                end
            end
            BUSY:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            op_reg      <= '0;
            dvd_reg     <= '0;
            dsr_reg     <= '0;
            rem_reg     <= '0;
            rs1_reg     <= '0;
            neg_quo_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            div0_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
            result_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg      <= op;
                        dvd_reg     <= rs1_mag;
                        dsr_reg     <= rs2_mag;
                        rem_reg     <= '0;
                        rs1_reg     <= rs1;
                        cnt_reg     <= '0;
                        neg_quo_reg <= rs1_neg ^ rs2_neg;
                        neg_rem_reg <= rs1_neg;
                        div0_reg    <= div0_in;
                        ovf_reg     <= ovf_in;
`ifdef DIV_EARLY_OUT_EN
                        if (special_in)
                            result_reg <= special_res(op, div0_in, rs1);
`endif
                    end
                end
                BUSY: begin
                    // A flush abandons the divide: state returns to IDLE and
                    // the datapath is simply left for the next accept to reload.
                    if (!flush) begin
                        dvd_reg <= dvd_step;
                        rem_reg <= rem_step;
                        cnt_reg <= last_step ? '0 : cnt_reg + CW'(1);
                        if (last_step)
                            result_reg <= final_res;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign done         = (state_reg == DONE);
    assign result       = result_reg;
    assign stall_req_ex = ~rst & ~flush &
                          (((state_reg == IDLE) & start) | (state_reg == BUSY));

endmodule
